sr_latch_driver: RTL and testbench

- Clocked controller that drives the active-low set/clear inputs of an asynchronous cross-coupled NAND SR latch and reads back its Q/Qbar outputs.
- Converts single-cycle set/clear requests into a glitch-free, fixed-width, never-overlapping low pulse.
- Synchronises the latch outputs and confirms the latch reached the commanded state, with timeout error reporting.
- Sits between synchronous control logic and any NAND latch instance.

---
 rtl/sr_latch_driver_pkg.sv | 21 ++
 rtl/sr_latch_driver_sync_ff.sv | 25 ++
 rtl/sr_latch_driver.sv | 135 +++++++++++++
 tb/tb_sr_latch_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_driver_pkg.sv
// Shared constants for the NAND SR latch driver: FSM encoding, counter width
// and the idle level of the active-low latch inputs.
package sr_latch_driver_pkg;

    localparam int   CNT_W    = 8;
    localparam logic OUT_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PULSE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

    // Counters run down to zero, so a phase of N cycles loads N-1.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync_ff.sv
// Multi-stage synchroniser for one asynchronous latch readback bit.
module sync_ff
    import sr_latch_driver_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the active-low set/clear inputs of a cross-coupled NAND latch with a
// fixed-width pulse and confirms the latch state through synchronised readback.
module sr_latch_driver
    import sr_latch_driver_pkg::*;
#(
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_in,
    input  logic qbar_in,
    output logic set_n,
    output logic clr_n,
    output logic busy,
    output logic done,
    output logic err,
    output logic req_drop,
    output logic q_sync
);

    state_e           state_q, state_d;
    logic             cmd_q, cmd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             set_n_q, set_n_d;
    logic             clr_n_q, clr_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             drop_q, drop_d;
    logic             qbar_sync;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
        .clk (clk),
        .rst (rst),
        .d_i (q_in),
        .q_o (q_sync)
    );

    sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_qbar (
        .clk (clk),
        .rst (rst),
        .d_i (qbar_in),
        .q_o (qbar_sync)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        set_n_d = OUT_IDLE;
        clr_n_d = OUT_IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
        drop_d  = busy_q && (set_req || clr_req);

        unique case (state_q)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    err_d = 1'b1;
                end else if (set_req || clr_req) begin
                    cmd_d   = set_req;
                    cnt_d   = cnt_load(PULSE_CYCLES);
                    set_n_d = ~set_req;
                    clr_n_d = ~clr_req;
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                // Both outputs fall back to idle on the exit edge, so the
                // low phase spans exactly PULSE_CYCLES cycles.
                if (cnt_q == '0) begin
                    cnt_d   = cnt_load(TIMEOUT_CYCLES);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    set_n_d = ~cmd_q;
                    clr_n_d = cmd_q;
                end
            end
            ST_WAIT: begin
                // Q=Qbar=1 can never satisfy this, leaving only the timeout.
                if ((q_sync == cmd_q) && (qbar_sync == ~cmd_q)) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= 1'b0;
            cnt_q   <= '0;
            set_n_q <= OUT_IDLE;
            clr_n_q <= OUT_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            set_n_q <= set_n_d;
            clr_n_q <= clr_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign set_n    = set_n_q;
    assign clr_n    = clr_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign req_drop = drop_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a behavioural NAND SR latch.
module tb_sr_latch_driver;

    localparam int PULSE = 4;
    localparam int TMO   = 16;
    localparam int SYNC  = 2;

    localparam int EV_DONE = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_DROP = 2;
    localparam int PL_SET  = 0;
    localparam int PL_CLR  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q_in, qbar_in;
    logic set_n, clr_n, busy, done, err, req_drop, q_sync;

    // Latch starts in a consistent Q=0 state; its inputs are held idle until
    // the DUT has come out of reset.
    logic lat_en = 1'b0;
    logic disc   = 1'b0;
    logic q_lat    = 1'b0;
    logic qbar_lat = 1'b1;
    logic lat_s_n, lat_r_n;

    assign lat_s_n = set_n | ~lat_en;
    assign lat_r_n = clr_n | ~lat_en;

    always @(lat_s_n or qbar_lat) q_lat    <= #1 ~(lat_s_n & qbar_lat);
    always @(lat_r_n or q_lat)    qbar_lat <= #1 ~(lat_r_n & q_lat);

    assign q_in    = disc ? 1'b0 : q_lat;
    assign qbar_in = disc ? 1'b1 : qbar_lat;

    sr_latch_driver #(
        .PULSE_CYCLES   (PULSE),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .q_in     (q_in),
        .qbar_in  (qbar_in),
        .set_n    (set_n),
        .clr_n    (clr_n),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .req_drop (req_drop),
        .q_sync   (q_sync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; } ev_t;
    typedef struct { int kind; int start; int width; } pl_t;

    ev_t ev_q[$];
    pl_t pl_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take_ev(input int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = ev_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic take_pl(input int kind, input int start, input int width);
        pl_t p;
        if (pl_q.size() == 0) begin
            chk("unexpected_pulse_kind", kind, -1);
        end else begin
            p = pl_q.pop_front();
            chk("pulse_kind", kind, p.kind);
            chk("pulse_start", start, p.start);
            chk("pulse_width", width, p.width);
        end
    endtask

    // Monitor: compares every observed output event against the scoreboard.
    bit   mon_en  = 1'b0;
    logic s_prev  = 1'b1;
    logic c_prev  = 1'b1;
    int   s_start = 0;
    int   c_start = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("no_overlap", int'(set_n | clr_n), 1);
            if (done)     take_ev(EV_DONE);
            if (err)      take_ev(EV_ERR);
            if (req_drop) take_ev(EV_DROP);
            if (!set_n && s_prev) s_start = cyc;
            if (set_n && !s_prev) take_pl(PL_SET, s_start, cyc - s_start);
            if (!clr_n && c_prev) c_start = cyc;
            if (clr_n && !c_prev) take_pl(PL_CLR, c_start, cyc - c_start);
            s_prev = set_n;
            c_prev = clr_n;
        end
    end

    int r;

    initial begin
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        lat_en = 1'b1;
        mon_en = 1'b1;
        chk("rst_set_n", set_n, 1);
        chk("rst_clr_n", clr_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_drop", req_drop, 0);
        chk("rst_q_sync", q_sync, 0);
        repeat (4) @(negedge clk);

        // Set from Q=0
        r = cyc + 1;
        pl_q.push_back('{PL_SET, r, PULSE});
        ev_q.push_back('{EV_DONE, r + PULSE + 1});
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        chk("busy_after_set", busy, 1);
        repeat (10) @(negedge clk);
        chk("q_sync_after_set", q_sync, 1);
        chk("busy_idle_after_set", busy, 0);

        // Clear from Q=1
        r = cyc + 1;
        pl_q.push_back('{PL_CLR, r, PULSE});
        ev_q.push_back('{EV_DONE, r + PULSE + 1});
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("q_sync_after_clr", q_sync, 0);

        // Simultaneous set and clear
        r = cyc + 1;
        ev_q.push_back('{EV_ERR, r});
        set_req = 1'b1;
        clr_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        clr_req = 1'b0;
        chk("busy_illegal_req", busy, 0);
        @(negedge clk);
        chk("busy_illegal_req_next", busy, 0);
        repeat (5) @(negedge clk);

        // Readback stuck at Q=0: timeout
        disc = 1'b1;
        repeat (4) @(negedge clk);
        r = cyc + 1;
        pl_q.push_back('{PL_SET, r, PULSE});
        ev_q.push_back('{EV_ERR, r + PULSE + TMO});
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        repeat (25) @(negedge clk);
        chk("busy_after_timeout", busy, 0);
        disc = 1'b0;
        repeat (5) @(negedge clk);
        chk("q_sync_reconnected", q_sync, 1);

        // Request while busy is dropped
        r = cyc + 1;
        pl_q.push_back('{PL_SET, r, PULSE});
        ev_q.push_back('{EV_DROP, r + 2});
        ev_q.push_back('{EV_DONE, r + PULSE + 1});
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("q_sync_after_drop", q_sync, 1);

        // Reset in the second cycle of a set pulse
        r = cyc + 1;
        pl_q.push_back('{PL_SET, r, 2});
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("busy_after_abort", busy, 0);
        chk("set_n_after_abort", set_n, 1);
        repeat (4) @(negedge clk);

        r = cyc + 1;
        pl_q.push_back('{PL_CLR, r, PULSE});
        ev_q.push_back('{EV_DONE, r + PULSE + 1});
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (10) @(negedge clk);
        chk("q_sync_after_abort_clr", q_sync, 0);

        chk("events_outstanding", ev_q.size(), 0);
        chk("pulses_outstanding", pl_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
